arb_client: RTL and testbench
=============================

Name: arb_client

Overview:
- Requester-side endpoint for the round-robin arbiter: one instance per client of a shared bus.
- Buffers words from a local producer in a small FIFO.
- Raises req to the arbiter while it has data, and drives one word onto the shared bus in every cycle its grant bit is high.
- Enforces a burst limit so a single client cannot hog the bus, and flags grants received without a request.

Parameters:
W, 8, data word width
DEPTH, 4, FIFO depth in words (power of two, >= 2)
MAX_BURST, 3, max consecutive granted cycles before req is forced low for one cycle (>= 1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
in_valid  input  1  producer has a word
in_ready  output  1  FIFO can accept; equals !full
in_data  input  W  producer word
req  output  1  request to arbiter (one bit of the arbiter's req vector)
grant  input  1  matching grant bit from arbiter (combinational, same cycle)
bus_data  output  W  FIFO head word, valid whenever req=1
bus_valid  output  1  req & grant: word transferred this cycle
count  output  $clog2(DEPTH+1)  words currently buffered
err  output  1  sticky: grant seen while req=0

Behaviour:
- Reset (rst=0, async): FIFO empty, count=0, burst_cnt=0, state=IDLE, req=0, in_ready=1, err=0, bus_data=0.
- req is a registered/state-only function; it must never depend combinationally on grant (grant depends on req through the arbiter; no loop allowed).
- Push: in_valid & in_ready writes in_data at wr_ptr on the clock edge.
- Pop: req & grant pops the head on the same edge; bus_data shows the head combinationally from FIFO storage.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Push when full: impossible (in_ready=0); producer must hold.
- FSM, 3 states:
  - IDLE: req=0. Go to REQ when count>0.
  - REQ: req=1, bus_data=head.
    - On grant: burst_cnt++.
    - If this pop empties the FIFO (count==1 and no push), go to IDLE with burst_cnt=0.
    - Else if burst_cnt==MAX_BURST-1, go to COOL with burst_cnt=0.
    - A cycle in REQ without grant holds burst_cnt. The burst counts granted cycles since the last REQ entry, not strictly back-to-back ones.
  - COOL: req=0 for exactly one cycle, then REQ if count>0, else IDLE.
- Latency: a word pushed into an empty FIFO at edge t gives req=1 in cycle t+1; the earliest transfer (bus_valid) is cycle t+1.
- Grant while req=0 (IDLE/COOL): ignored, no pop, err<=1 (sticky until reset).
- Reset asserted mid-burst: everything returns to reset values immediately; buffered words are discarded.

Decomposition:
- Package arb_pkg: state enum typedef (IDLE, REQ, COOL) and the default W/DEPTH/MAX_BURST localparams, shared with arbiter-level testbenches.
- One natural sub-module: arb_client_fifo (storage, pointers, count, full/empty).
- The FSM and burst counter live in arb_client.

Test Plan:
- Reset with rst=0 mid-stream -> req=0, count=0, err=0, in_ready=1 immediately, without waiting for clk.
- Push 0x11,0x22 with grant tied to req -> bus_valid in two consecutive cycles carrying 0x11 then 0x22; req falls the next cycle; count returns to 0.
- Fill with 4 words (DEPTH=4), grant held 0 -> in_ready=0, count=4, req stays 1; 5th in_valid is held off, not lost.
- Push 5 words, grant always 1 (MAX_BURST=3) -> transfers 3, req=0 for 1 cycle, then 2 more; order 0..4 preserved.
- Two arb_client instances connected to arbiter N=2, both full -> grants alternate, each sees COOL after 3 grants; no word lost or duplicated; err=0.
- Drive grant=1 while FIFO empty -> err=1 and stays 1; count unchanged; no bus_valid.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter client: FSM state encoding and default sizing,
// also used by arbiter-level testbenches.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        COOL = 2'd2
    } arb_state_e;

    localparam int ARB_W         = 8;
    localparam int ARB_DEPTH     = 4;
    localparam int ARB_MAX_BURST = 3;

    // Width needed to hold a burst count of 0..max_burst-1 (at least one bit).
    function automatic int burst_cnt_w(input int max_burst);
        return (max_burst < 2) ? 1 : $clog2(max_burst);
    endfunction

endpackage

// File: rtl/arb_client_fifo.sv
// Small synchronous FIFO holding producer words until the shared bus takes them.
// Head word is visible combinationally; storage clears on reset so the head reads 0.
module arb_client_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/arb_client.sv
// Requester endpoint for a shared round-robin bus: buffers producer words, requests the
// bus while data is pending, and caps each burst at MAX_BURST granted cycles.
module arb_client
    import arb_pkg::*;
#(
    parameter int W         = ARB_W,
    parameter int DEPTH     = ARB_DEPTH,
    parameter int MAX_BURST = ARB_MAX_BURST
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_data,
    output logic                       req,
    input  logic                       grant,
    output logic [W-1:0]               bus_data,
    output logic                       bus_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err,
    output arb_state_e                 state_dbg
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int BW = burst_cnt_w(MAX_BURST);

    // Handshakes: a producer word moves on any edge where in_valid & in_ready; a bus word
    // moves on any edge where req & grant. Neither side may retract data it has offered.
    arb_state_e    state;
    arb_state_e    state_nxt;
    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_nxt;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;

    assign in_ready  = ~full;
    assign push      = in_valid & in_ready;
    assign req       = (state == REQ);
    assign pop       = req & grant;
    assign bus_valid = pop;
    assign state_dbg = state;

    arb_client_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head      (bus_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // req is taken from state alone so the arbiter's grant cannot loop back into it.
    always_comb begin
        state_nxt = state;
        burst_nxt = burst_cnt;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (grant) begin
                    if (count == CW'(1) && !push) begin
                        state_nxt = IDLE;
                        burst_nxt = '0;
                    end else if (burst_cnt == BW'(MAX_BURST - 1)) begin
                        state_nxt = COOL;
                        burst_nxt = '0;
                    end else begin
                        burst_nxt = burst_cnt + 1'b1;
                    end
                end
            end
            COOL: begin
                state_nxt = empty ? IDLE : REQ;
            end
            default: begin
                state_nxt = IDLE;
                burst_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            if (grant && !req) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arb_client.sv
// Bench for arb_client: directed scenarios plus randomized traffic, checked by a
// negedge monitor against a queue-based model of the client's observable rules.
module tb_arb_client;
    import arb_pkg::*;

    localparam int W         = 8;
    localparam int DEPTH     = 4;
    localparam int MAX_BURST = 3;
    localparam int CW        = $clog2(DEPTH+1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data  = '0;
    logic          in_ready;
    logic          req;
    logic          grant;
    logic [W-1:0]  bus_data;
    logic          bus_valid;
    logic [CW-1:0] count;
    logic          err;
    arb_state_e    state_dbg;

    // Grant either follows req (well-behaved arbiter) or is forced from g_en.
    logic g_follow = 1'b0;
    logic g_en     = 1'b0;
    assign grant = g_follow ? (req & g_en) : g_en;

    arb_client #(
        .W         (W),
        .DEPTH     (DEPTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .req       (req),
        .grant     (grant),
        .bus_data  (bus_data),
        .bus_valid (bus_valid),
        .count     (count),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard / model state ----------------
    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    int           model_count = 0;
    bit           model_err   = 1'b0;
    int           run_g       = 0;
    bit           prev_req    = 1'b0;
    int           low_cnt     = 0;
    int           runs_q[$];
    int           cyc         = 0;
    logic [W-1:0] log_d[$];
    int           log_c[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        bit push_m;
        bit pop_m;
        cyc++;
        if (!rst) begin
            exp_q.delete();
            model_count = 0;
            model_err   = 1'b0;
            run_g       = 0;
            prev_req    = 1'b0;
            low_cnt     = 0;
        end else begin
            check("count", 32'(count), 32'(model_count));
            check("in_ready", 32'(in_ready), 32'(model_count < DEPTH));
            check("err", 32'(err), 32'(model_err));
            check("bus_valid", 32'(bus_valid), 32'(req & grant));
            if (model_count == 0) check("req_when_empty", 32'(req), 32'd0);

            // With data buffered, req may be low for at most one cycle at a time.
            if (!req && model_count > 0) low_cnt++;
            else low_cnt = 0;
            if (low_cnt > 0) check("req_gap", 32'(low_cnt), 32'd1);

            // After MAX_BURST granted cycles in one request run, req must drop.
            if (prev_req && run_g >= MAX_BURST) check("burst_limit", 32'(req), 32'd0);
            if (req) begin
                if (bus_valid) run_g++;
            end else begin
                if (prev_req) runs_q.push_back(run_g);
                run_g = 0;
            end

            if (bus_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_underflow: got 0x%0h, expected no transfer (t=%0t)", bus_data, $time);
                end else begin
                    check("bus_data", 32'(bus_data), 32'(exp_q.pop_front()));
                end
                log_d.push_back(bus_data);
                log_c.push_back(cyc);
            end

            push_m = in_valid && (model_count < DEPTH);
            pop_m  = req && grant && (model_count > 0);
            if (push_m) exp_q.push_back(in_data);
            model_count = model_count + int'(push_m) - int'(pop_m);
            if (grant && !req) model_err = 1'b1;
            prev_req = req;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_word(input logic [W-1:0] d);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        t = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                checks++;
                errors++;
                $display("FAIL push_timeout: got in_ready=0 for 200 cycles, expected acceptance");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (1) begin
            @(negedge clk);
            if (model_count == 0 && !req) break;
            t++;
            if (t > 300) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: got count=%0d after 300 cycles, expected 0", count);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_req"}, 32'(req), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_bus_valid"}, 32'(bus_valid), 32'd0);
        check({tag, "_bus_data"}, 32'(bus_data), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2 rst = 1'b0;
        #1 reset_check("rst0");
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // Two words with grant following req: back-to-back transfers in order.
        g_follow = 1'b1;
        g_en     = 1'b1;
        log_d.delete();
        log_c.delete();
        push_word(8'h11);
        push_word(8'h22);
        wait_drain();
        check("pair_n", 32'(log_d.size()), 32'd2);
        if (log_d.size() == 2) begin
            check("pair_0", 32'(log_d[0]), 32'h11);
            check("pair_1", 32'(log_d[1]), 32'h22);
            check("pair_consec", 32'(log_c[1] - log_c[0]), 32'd1);
        end
        check("pair_count", 32'(count), 32'd0);
        check("pair_req", 32'(req), 32'd0);

        // Fill with no grant, hold a 5th word, then release: bursts of 3 then 2.
        g_follow = 1'b0;
        g_en     = 1'b0;
        runs_q.delete();
        log_d.delete();
        log_c.delete();
        for (int i = 0; i < DEPTH; i++) push_word(8'hA0 + 8'(i));
        fork
            push_word(8'hA4);
            begin
                repeat (3) @(negedge clk);
                check("full_count", 32'(count), 32'(DEPTH));
                check("full_in_ready", 32'(in_ready), 32'd0);
                check("full_req", 32'(req), 32'd1);
                @(posedge clk);
                #1;
                g_follow = 1'b1;
                g_en     = 1'b1;
            end
        join
        wait_drain();
        check("burst_runs_n", 32'(runs_q.size()), 32'd2);
        if (runs_q.size() == 2) begin
            check("burst_run0", 32'(runs_q[0]), 32'(MAX_BURST));
            check("burst_run1", 32'(runs_q[1]), 32'd2);
        end
        check("burst_words", 32'(log_d.size()), 32'd5);
        for (int i = 0; i < log_d.size(); i++) check("burst_order", 32'(log_d[i]), 32'(8'hA0 + 8'(i)));

        // Grant while idle: sticky err, nothing popped.
        g_follow = 1'b0;
        g_en     = 1'b1;
        repeat (3) @(negedge clk);
        check("spur_err", 32'(err), 32'd1);
        check("spur_count", 32'(count), 32'd0);
        check("spur_bus_valid", 32'(bus_valid), 32'd0);
        @(posedge clk);
        #1;
        g_en = 1'b0;
        repeat (4) @(negedge clk);
        check("spur_sticky", 32'(err), 32'd1);
        @(posedge clk);
        #1;

        // Asynchronous reset with words buffered, asserted between clock edges.
        for (int i = 0; i < 3; i++) push_word(8'h30 + 8'(i));
        #2 rst = 1'b0;
        #1 reset_check("rst_mid");
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic with a mostly well-behaved arbiter.
        for (int c = 0; c < 800; c++) begin
            in_valid = ($urandom_range(0, 99) < 60);
            in_data  = W'($urandom);
            g_follow = ($urandom_range(0, 19) != 0);
            g_en     = ($urandom_range(0, 99) < 70);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        g_follow = 1'b1;
        g_en     = 1'b1;
        wait_drain();
        check("leftover", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish by 200000, expected completion");
        $fatal(1, "timeout");
    end

endmodule
